// File: rtl/pc_gen_stage_pkg.sv
// rtl/pc_gen_stage_pkg.sv - shared types, constants and helpers for the fetch PC generator
package pc_gen_stage_pkg;

  localparam int INST_NUM = 4;
  localparam logic [INST_NUM-1:0] FOUR_WORDS  = 4'b1111;
  localparam logic [INST_NUM-1:0] SINGLE_WORD = 4'b0001;
  localparam logic [31:0] RESET_VADDR_DEFAULT = 32'hBFC0_0000;

  // NORMAL fetches whole groups; SLOT fetches only the delay slot of a taken branch
  typedef enum logic {
    PCG_STATE_NORMAL = 1'b0,
    PCG_STATE_SLOT   = 1'b1
  } pcg_state_e;

  // Decision produced by the next-PC mux for the register stage
  typedef struct packed {
    logic [31:0] pc;
    pcg_state_e  state;
    logic        save_target;
    logic        discard_target;
  } pcg_next_t;

  // Slot enables: from pc[3:2] upward in NORMAL, only the delay slot in SLOT
  function automatic logic [INST_NUM-1:0] slot_enable(input pcg_state_e state,
                                                     input logic [1:0] slot);
    logic [INST_NUM-1:0] en;
    if (state == PCG_STATE_SLOT) begin
      en = SINGLE_WORD << slot;
    end else begin
      en = FOUR_WORDS << slot;
    end
    return en;
  endfunction

  // Fetch group: word0 is the exact pc, words 1..3 are the aligned words of its 16B group
  function automatic logic [32*INST_NUM-1:0] fetch_group(input logic [31:0] pc);
    logic [32*INST_NUM-1:0] grp;
    grp[31:0] = pc;
    for (int i = 1; i < INST_NUM; i++) begin
      grp[32*i +: 32] = {pc[31:4], 2'(i), 2'b00};
    end
    return grp;
  endfunction

endpackage

// File: rtl/pc_gen_stage_if.sv
// rtl/pc_gen_stage_if.sv - redirect, BTB and fetch-request signals of the PC generator
interface pc_gen_stage_if;

  logic         EX_redirect_i;
  logic [31:0]  EX_redirectVAddr_i;
  logic         FU_redirect_i;
  logic [31:0]  FU_redirectVAddr_i;
  logic         IC_ready_i;
  logic [31:0]  BTB_validDest_i;
  logic         BTB_validTake_i;
  logic         BTB_needDelaySlot_i;
  logic [31:0]  BTB_fifthVAddr_i;
  logic         PCG_valid_o;
  logic [127:0] PCG_VAddr_p_o;
  logic [3:0]   PCR_instEnable_o;
  logic         PCG_needDelaySlot_o;
  logic         PCG_addrErr_o;

  // PC generator side
  modport master (
    input  EX_redirect_i, EX_redirectVAddr_i,
    input  FU_redirect_i, FU_redirectVAddr_i,
    input  IC_ready_i,
    input  BTB_validDest_i, BTB_validTake_i, BTB_needDelaySlot_i, BTB_fifthVAddr_i,
    output PCG_valid_o, PCG_VAddr_p_o, PCR_instEnable_o,
    output PCG_needDelaySlot_o, PCG_addrErr_o
  );

  // Consumer side: redirect sources, BTB and I-cache
  modport slave (
    output EX_redirect_i, EX_redirectVAddr_i,
    output FU_redirect_i, FU_redirectVAddr_i,
    output IC_ready_i,
    output BTB_validDest_i, BTB_validTake_i, BTB_needDelaySlot_i, BTB_fifthVAddr_i,
    input  PCG_valid_o, PCG_VAddr_p_o, PCR_instEnable_o,
    input  PCG_needDelaySlot_o, PCG_addrErr_o
  );

endinterface

// File: rtl/pc_gen_stage_next_pc_mux.sv
// rtl/pc_gen_stage_next_pc_mux.sv - priority select of next fetch PC and delay-slot sequencing
module pc_gen_stage_next_pc_mux
  import pc_gen_stage_pkg::*;
(
  input  logic        valid_i,
  input  logic        ic_ready_i,
  input  logic [31:0] pc_i,
  input  pcg_state_e  state_i,
  input  logic [31:0] saved_target_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_vaddr_i,
  input  logic        fu_redirect_i,
  input  logic [31:0] fu_vaddr_i,
  input  logic [31:0] btb_dest_i,
  input  logic        btb_need_ds_i,
  input  logic [31:0] btb_fifth_i,
  output pcg_next_t   next_o
);

  logic fire;

  assign fire = valid_i && ic_ready_i;

  // Exception beats branch repair beats an accepted fetch; otherwise hold everything
  always_comb begin
    next_o.pc             = pc_i;
    next_o.state          = state_i;
    next_o.save_target    = 1'b0;
    next_o.discard_target = 1'b0;
    if (ex_redirect_i) begin
      next_o.pc             = ex_vaddr_i;
      next_o.state          = PCG_STATE_NORMAL;
      next_o.discard_target = 1'b1;
    end else if (fu_redirect_i) begin
      next_o.pc             = fu_vaddr_i;
      next_o.state          = PCG_STATE_NORMAL;
      next_o.discard_target = 1'b1;
    end else if (fire) begin
      if (state_i == PCG_STATE_SLOT) begin
        // Delay slot accepted: now go to the branch target remembered earlier
        next_o.pc    = saved_target_i;
        next_o.state = PCG_STATE_NORMAL;
      end else if (btb_need_ds_i) begin
        // Taken branch in the last slot: fetch its delay slot first, park the target
        next_o.pc          = btb_fifth_i;
        next_o.state       = PCG_STATE_SLOT;
        next_o.save_target = 1'b1;
      end else begin
        next_o.pc = btb_dest_i;
      end
    end
  end

endmodule

// File: rtl/pc_gen_stage.sv
// rtl/pc_gen_stage.sv - fetch PC register stage driving the BTB and I-cache request
module pc_gen_stage
  import pc_gen_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VADDR = RESET_VADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_stage_if.master  bus
);

  logic [31:0] pc_q, pc_d;
  pcg_state_e  state_q, state_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic        valid_q, valid_d;
  pcg_next_t   nxt;
  logic        unused_btb_take;

  // The BTB folds taken/not-taken into validDest and needDelaySlot already
  assign unused_btb_take = bus.BTB_validTake_i;

  pc_gen_stage_next_pc_mux u_next_pc_mux (
    .valid_i        (valid_q),
    .ic_ready_i     (bus.IC_ready_i),
    .pc_i           (pc_q),
    .state_i        (state_q),
    .saved_target_i (saved_target_q),
    .ex_redirect_i  (bus.EX_redirect_i),
    .ex_vaddr_i     (bus.EX_redirectVAddr_i),
    .fu_redirect_i  (bus.FU_redirect_i),
    .fu_vaddr_i     (bus.FU_redirectVAddr_i),
    .btb_dest_i     (bus.BTB_validDest_i),
    .btb_need_ds_i  (bus.BTB_needDelaySlot_i),
    .btb_fifth_i    (bus.BTB_fifthVAddr_i),
    .next_o         (nxt)
  );

  // Next register values; the request turns valid one edge after reset and stays valid
  always_comb begin
    pc_d           = nxt.pc;
    state_d        = nxt.state;
    saved_target_d = saved_target_q;
    valid_d        = 1'b1;
    if (nxt.discard_target) begin
      saved_target_d = 32'h0;
    end else if (nxt.save_target) begin
      saved_target_d = bus.BTB_validDest_i;
    end
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_VADDR;
      state_q        <= PCG_STATE_NORMAL;
      saved_target_q <= 32'h0;
      valid_q        <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      state_q        <= state_d;
      saved_target_q <= saved_target_d;
      valid_q        <= valid_d;
    end
  end

  // Request outputs depend only on registers, so they hold while the I-cache stalls
  always_comb begin
    bus.PCG_valid_o         = valid_q;
    bus.PCG_VAddr_p_o       = fetch_group(pc_q);
    bus.PCR_instEnable_o    = slot_enable(state_q, pc_q[3:2]);
    bus.PCG_needDelaySlot_o = (state_q == PCG_STATE_SLOT);
    bus.PCG_addrErr_o       = |pc_q[1:0];
  end

endmodule
